frogger_qsys_keypad_in: RTL and testbench

Avalon-MM slave input port for the Frogger Qsys system, in the opposite direction from the keycode output port. It samples an external parallel input bus from the fabric (controller buttons or decoded key flags), synchronises it into `clk`, and presents it to the Nios II CPU as a readable data register. It also latches input edges into a sticky, per-bit clearable edge-capture register and raises a maskable level interrupt, so software does not need to poll.

---
 rtl/frogger_qsys_keypad_in_if.sv | 25 ++
 rtl/frogger_qsys_keypad_in.sv | 88 ++++++++
 tb/tb_frogger_qsys_keypad_in.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/frogger_qsys_keypad_in_if.sv
// Avalon-MM slave bus bundle for the Frogger keypad input port.
// The CPU side (master) drives the strobes; the port (slave) returns read data.
interface frogger_qsys_keypad_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );
endinterface

// File: rtl/frogger_qsys_keypad_in.sv
// Keypad/controller input port: synchronises in_port, latches edges into a sticky
// write-1-to-clear capture register and raises a maskable level interrupt.
module frogger_qsys_keypad_in #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    frogger_qsys_keypad_in_if.slave   avs,
    input  logic [WIDTH-1:0]          in_port,
    output logic                      irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] data_sync;
    logic [WIDTH-1:0] data_prev_q;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] rise, fall, edge_hit, clear_bits;
    logic             wr_en;
    logic             unused_wdata;

    assign data_sync    = sync_q[SYNC_STAGES-1];
    assign wr_en        = avs.chipselect && !avs.write_n;
    assign unused_wdata = ^avs.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            data_prev_q <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], in_port};
            data_prev_q <= data_sync;
        end
    end

    always_comb begin
        rise     = data_sync & ~data_prev_q;
        fall     = ~data_sync & data_prev_q;
        edge_hit = rise ^ fall;
        case (EDGE_TYPE)
            0:       edge_hit = rise;
            1:       edge_hit = fall;
            default: edge_hit = rise ^ fall;
        endcase
    end

    // A fresh edge outranks a simultaneous clear so no event is ever lost.
    always_comb begin
        clear_bits = '0;
        irq_mask_d = irq_mask_q;
        if (wr_en && avs.address == 2'd3) begin
            clear_bits = avs.writedata[WIDTH-1:0];
        end
        if (wr_en && avs.address == 2'd2) begin
            irq_mask_d = avs.writedata[WIDTH-1:0];
        end
        edge_cap_d = (edge_cap_q & ~clear_bits) | edge_hit;
    end

    always_comb begin
        readdata_d = '0;
        case (avs.address)
            2'd0:    readdata_d[WIDTH-1:0] = data_sync;
            2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edge_cap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap_q <= '0;
            irq_mask_q <= '0;
            readdata_q <= '0;
        end else begin
            edge_cap_q <= edge_cap_d;
            irq_mask_q <= irq_mask_d;
            readdata_q <= readdata_d;
        end
    end

    assign avs.readdata = readdata_q;
    assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_frogger_qsys_keypad_in.sv
// Bench for frogger_qsys_keypad_in: three instances (rising, falling, any edge)
// share one stimulus stream; read results are scoreboarded per instance.
module tb_frogger_qsys_keypad_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic        irq0, irq1, irq2;

    int numChecks = 0;
    int numFails  = 0;

    typedef struct {
        string       tag;
        int          dut;
        logic [31:0] exp;
    } expect_t;

    expect_t sb[$];

    always #5 clk = ~clk;

    frogger_qsys_keypad_in_if bus0 ();
    frogger_qsys_keypad_in_if bus1 ();
    frogger_qsys_keypad_in_if bus2 ();

    assign bus0.address = address;    assign bus1.address = address;    assign bus2.address = address;
    assign bus0.chipselect = chipselect; assign bus1.chipselect = chipselect; assign bus2.chipselect = chipselect;
    assign bus0.write_n = write_n;    assign bus1.write_n = write_n;    assign bus2.write_n = write_n;
    assign bus0.writedata = writedata; assign bus1.writedata = writedata; assign bus2.writedata = writedata;

    frogger_qsys_keypad_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) dutRise (
        .clk(clk), .reset_n(reset_n), .avs(bus0.slave), .in_port(in_port), .irq(irq0));
    frogger_qsys_keypad_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1)) dutFall (
        .clk(clk), .reset_n(reset_n), .avs(bus1.slave), .in_port(in_port), .irq(irq1));
    frogger_qsys_keypad_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2)) dutAny (
        .clk(clk), .reset_n(reset_n), .avs(bus2.slave), .in_port(in_port), .irq(irq2));

    function automatic logic [31:0] readOf(input int d);
        case (d)
            0:       return bus0.readdata;
            1:       return bus1.readdata;
            default: return bus2.readdata;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        cycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
        applyStimulus(a, 1'b1, 1'b0, d);
    endtask

    task automatic readReg(input string tag, input logic [1:0] a,
                           input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        expect_t e;
        sb.push_back('{tag: $sformatf("%s_d0", tag), dut: 0, exp: e0});
        sb.push_back('{tag: $sformatf("%s_d1", tag), dut: 1, exp: e1});
        sb.push_back('{tag: $sformatf("%s_d2", tag), dut: 2, exp: e2});
        applyStimulus(a, 1'b1, 1'b1, 32'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e.tag, readOf(e.dut), e.exp);
        end
    endtask

    task automatic checkIrq(input string tag, input logic e0, input logic e1, input logic e2);
        checkOutput($sformatf("%s_irq0", tag), {31'b0, irq0}, {31'b0, e0});
        checkOutput($sformatf("%s_irq1", tag), {31'b0, irq1}, {31'b0, e1});
        checkOutput($sformatf("%s_irq2", tag), {31'b0, irq2}, {31'b0, e2});
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;
        repeat (3) cycle();
        reset_n = 1'b1;

        $display("[TB] reset defaults");
        checkIrq("rst", 1'b0, 1'b0, 1'b0);
        for (int a = 0; a < 4; a++) begin
            readReg($sformatf("rst_a%0d", a), 2'(a), 32'h0, 32'h0, 32'h0);
        end

        $display("[TB] data path");
        in_port = 8'hA5;
        cycle();
        readReg("data_early", 2'd0, 32'h0, 32'h0, 32'h0);
        readReg("data", 2'd0, 32'hA5, 32'hA5, 32'hA5);
        writeReg(2'd0, 32'hFFFF_FFFF);
        readReg("data_wr_ign", 2'd0, 32'hA5, 32'hA5, 32'hA5);
        writeReg(2'd1, 32'hFFFF_FFFF);
        readReg("reserved", 2'd1, 32'h0, 32'h0, 32'h0);
        in_port = 8'h00;
        repeat (4) cycle();
        writeReg(2'd3, 32'hFFFF_FFFF);
        readReg("cap_cleared", 2'd3, 32'h0, 32'h0, 32'h0);

        $display("[TB] rising capture and irq");
        writeReg(2'd2, 32'h1);
        readReg("mask1", 2'd2, 32'h1, 32'h1, 32'h1);
        in_port = 8'h01;
        cycle();
        cycle();
        checkIrq("rise_early", 1'b0, 1'b0, 1'b0);
        cycle();
        checkIrq("rise", 1'b1, 1'b0, 1'b1);
        in_port = 8'h00;
        readReg("rise_cap", 2'd3, 32'h01, 32'h00, 32'h01);
        repeat (3) cycle();
        checkIrq("fall", 1'b1, 1'b1, 1'b1);
        writeReg(2'd3, 32'h1);
        checkIrq("clr", 1'b0, 1'b0, 1'b0);
        readReg("clr_cap", 2'd3, 32'h0, 32'h0, 32'h0);

        $display("[TB] mask gating");
        writeReg(2'd2, 32'h0);
        in_port = 8'h88;
        repeat (4) cycle();
        checkIrq("gate_rise", 1'b0, 1'b0, 1'b0);
        readReg("gate_rise_cap", 2'd3, 32'h88, 32'h00, 32'h88);
        in_port = 8'h00;
        repeat (4) cycle();
        readReg("gate_cap", 2'd3, 32'h88, 32'h88, 32'h88);
        checkIrq("gate_masked", 1'b0, 1'b0, 1'b0);
        writeReg(2'd2, 32'h80);
        checkIrq("gate_unmask", 1'b1, 1'b1, 1'b1);
        writeReg(2'd3, 32'h08);
        readReg("gate_partial", 2'd3, 32'h80, 32'h80, 32'h80);
        checkIrq("gate_keep", 1'b1, 1'b1, 1'b1);
        writeReg(2'd3, 32'hFF);
        checkIrq("gate_clr", 1'b0, 1'b0, 1'b0);

        $display("[TB] set/clear collision");
        in_port = 8'h04;
        cycle();
        cycle();
        writeReg(2'd3, 32'h04);
        readReg("coll_rise", 2'd3, 32'h04, 32'h00, 32'h04);
        in_port = 8'h00;
        cycle();
        cycle();
        writeReg(2'd3, 32'h04);
        readReg("coll_fall", 2'd3, 32'h00, 32'h04, 32'h04);
        writeReg(2'd3, 32'h04);
        readReg("plain_clr", 2'd3, 32'h00, 32'h00, 32'h00);

        $display("[TB] async reset mid-operation");
        writeReg(2'd2, 32'hFF);
        in_port = 8'hFF;
        repeat (4) cycle();
        in_port = 8'h00;
        repeat (4) cycle();
        readReg("arst_pre", 2'd3, 32'hFF, 32'hFF, 32'hFF);
        checkIrq("arst_pre", 1'b1, 1'b1, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        checkIrq("arst", 1'b0, 1'b0, 1'b0);
        checkOutput("arst_rd0", bus0.readdata, 32'h0);
        checkOutput("arst_rd1", bus1.readdata, 32'h0);
        checkOutput("arst_rd2", bus2.readdata, 32'h0);
        #1;
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            readReg($sformatf("arst_a%0d", a), 2'(a), 32'h0, 32'h0, 32'h0);
        end
        checkIrq("arst_post", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
